// File: rtl/uart_tx_path.sv
`timescale 1ns/1ps
// uart_tx_path: TX holding FIFO, baud prescaler and 8N1 serialiser (16 enables per bit).
// Ports: s_axi_aclk/s_axi_aresetn clock and async active-low reset; addr_in/we/w_data_in register write;
// tx_fifo_clr FIFO flush; dl baud divisor (0 halts); tf_overrun/tf_count/tf_empty FIFO status;
// tx_busy serialiser active; stx_o serial line.
module uart_tx_path #(
  parameter int ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] TR_ADDR = 5'h00,
  parameter int DEPTH = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic                    we,
  input  logic [7:0]              w_data_in,
  input  logic                    tx_fifo_clr,
  input  logic [15:0]             dl,
  output logic                    tf_overrun,
  output logic [$clog2(DEPTH):0]  tf_count,
  output logic                    tf_empty,
  output logic                    tx_busy,
  output logic                    stx_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic empty_q, empty_d, ovr_q, ovr_d;
  logic [15:0] presc_q, presc_d, dl_q;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bitc_q, bitc_d;
  logic [7:0] shift_q, shift_d;
  logic push_req, push, pop, full, reload, en, last;
  always_comb begin
    push_req = we && addr_in == TR_ADDR;
    pop = state_q == IDLE && !empty_q && dl != '0 && !tx_fifo_clr;
    full = count_q == CW'(DEPTH);
    push = push_req && (!full || pop);
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = w_data_in;
    wr_ptr_d = tx_fifo_clr ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = tx_fifo_clr ? '0 : rd_ptr_q + AW'(pop);
    count_d = tx_fifo_clr ? '0 : count_q + CW'(push) - CW'(pop);
    empty_d = count_d == '0;
    ovr_d = (tx_fifo_clr || push) ? 1'b0 : push_req ? 1'b1 : ovr_q;
  end
  // The prescaler is also held in reload while idle so every character starts on a full bit time.
  always_comb begin
    reload = dl == '0 || dl != dl_q || state_q == IDLE;
    en = !reload && presc_q == dl - 16'd1;
    presc_d = (reload || en) ? '0 : presc_q + 16'd1;
    last = en && tick_q == 4'd15;
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bitc_d = bitc_q;
    tick_d = tick_q + 4'(en);
    case (state_q)
      IDLE: if (pop) begin
        state_d = START;
        shift_d = mem_q[rd_ptr_q];
        bitc_d = '0;
        tick_d = '0;
      end
      START: if (last) state_d = DATA;
      DATA: if (last) begin
        shift_d = shift_q >> 1;
        bitc_d = bitc_q + 3'd1;
        if (bitc_q == 3'd7) state_d = STOP;
      end
      STOP: if (last) state_d = IDLE;
    endcase
  end
  always_ff @(posedge s_axi_aclk) mem_q <= mem_d;
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      ovr_q <= 1'b0;
      presc_q <= '0;
      dl_q <= '0;
      state_q <= IDLE;
      tick_q <= '0;
      bitc_q <= '0;
      shift_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      ovr_q <= ovr_d;
      presc_q <= presc_d;
      dl_q <= dl;
      state_q <= state_d;
      tick_q <= tick_d;
      bitc_q <= bitc_d;
      shift_q <= shift_d;
    end
  end
  assign tf_overrun = ovr_q;
  assign tf_count = count_q;
  assign tf_empty = empty_q;
  assign tx_busy = state_q != IDLE;
  assign stx_o = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
endmodule

// File: tb/tb_uart_tx_path.sv
`timescale 1ns/1ps
// tb_uart_tx_path: directed self-checking bench for uart_tx_path.
module tb_uart_tx_path;
  logic clk = 1'b0, rstn = 1'b0, we = 1'b0, clr = 1'b0;
  logic [4:0] addr = '0;
  logic [7:0] data = '0;
  logic [15:0] dl = '0;
  logic ovr, empty, busy, stx;
  logic [4:0] count;
  int n_assert = 0, n_fail = 0;
  uart_tx_path dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .addr_in(addr), .we(we), .w_data_in(data),
    .tx_fifo_clr(clr), .dl(dl), .tf_overrun(ovr), .tf_count(count), .tf_empty(empty),
    .tx_busy(busy), .stx_o(stx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a;
    data = d;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask
  task automatic rx(input int d, output logic [7:0] b, output logic ok);
    int t = 0;
    ok = 1'b1;
    b = '0;
    while (stx === 1'b1 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) ok = 1'b0;
    cyc(8 * d);
    if (stx !== 1'b0) ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(16 * d);
      b[i] = stx;
    end
    cyc(16 * d);
    if (stx !== 1'b1) ok = 1'b0;
  endtask
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b, a5;
    logic ok;
    cyc(3);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ovr", ovr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stx", stx, 1);
    @(negedge clk);
    rstn = 1'b1;
    addr = 5'h00;
    data = 8'h77;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("first_push_count", count, 1);
    chk("first_push_empty", empty, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    dl = 16'd1;
    cyc(2);
    wr(5'h00, 8'hA5);
    chk("a5_push_count", count, 1);
    chk("a5_push_empty", empty, 0);
    chk("a5_push_stx", stx, 1);
    a5 = 8'hA5;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("a5_pop_empty", empty, 1);
        chk("a5_busy", busy, 1);
      end
      chk("a5_wave", stx, k < 16 ? 1'b0 : k < 144 ? a5[(k - 16) / 16] : 1'b1);
    end
    @(negedge clk);
    chk("a5_done_busy", busy, 0);
    chk("a5_done_stx", stx, 1);
    wr(5'h03, 8'hFF);
    chk("other_addr_count", count, 0);
    chk("other_addr_empty", empty, 1);
    cyc(5);
    chk("other_addr_stx", stx, 1);
    chk("other_addr_busy", busy, 0);
    dl = 16'd0;
    cyc(1);
    for (int i = 0; i < 16; i++) wr(5'h00, 8'(i));
    chk("full_count", count, 16);
    chk("full_ovr", ovr, 0);
    wr(5'h00, 8'h10);
    chk("ovr17_flag", ovr, 1);
    chk("ovr17_count", count, 16);
    wr(5'h00, 8'h11);
    chk("ovr18_flag", ovr, 1);
    chk("ovr18_count", count, 16);
    @(negedge clk);
    dl = 16'd2;
    addr = 5'h00;
    data = 8'h55;
    we = 1'b1;
    @(negedge clk);
    we = 1'b0;
    chk("poppush_count", count, 16);
    chk("poppush_ovr", ovr, 0);
    chk("poppush_busy", busy, 1);
    for (int i = 0; i < 17; i++) begin
      rx(2, b, ok);
      chk("seq_frame", ok, 1);
      chk("seq_byte", b, i < 16 ? 8'(i) : 8'h55);
    end
    cyc(40);
    chk("seq_done_empty", empty, 1);
    chk("seq_done_busy", busy, 0);
    dl = 16'd0;
    cyc(2);
    for (int i = 0; i < 5; i++) wr(5'h00, 8'(8'h20 + i));
    chk("five_count", count, 5);
    @(negedge clk);
    clr = 1'b1;
    data = 8'hAA;
    we = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    we = 1'b0;
    chk("clrw_count", count, 0);
    chk("clrw_empty", empty, 1);
    chk("clrw_ovr", ovr, 0);
    dl = 16'd1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("clrw_stx", stx, 1);
    end
    chk("clrw_busy", busy, 0);
    dl = 16'd0;
    cyc(1);
    for (int i = 0; i < 17; i++) wr(5'h00, 8'(i));
    chk("ovr_set", ovr, 1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("ovr_clr_flag", ovr, 0);
    chk("ovr_clr_count", count, 0);
    dl = 16'd3;
    cyc(2);
    wr(5'h00, 8'h9A);
    wr(5'h00, 8'h21);
    cyc(215);
    chk("mid_bit3_stx", stx, 1);
    chk("mid_busy", busy, 1);
    chk("mid_count", count, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_stx", stx, 1);
    chk("arst_busy", busy, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ovr", ovr, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(2);
    wr(5'h00, 8'h3C);
    rx(3, b, ok);
    chk("post_rst_frame", ok, 1);
    chk("post_rst_byte", b, 8'h3C);
    cyc(60);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_path.md
UART_TX_PATH -- requirements
Module: uart_tx_path

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, width of the register address bus.
REQ-002 SHALL have parameter TR_ADDR, default 5'h00, the transmit-holding register address.
REQ-003 SHALL have parameter DEPTH, default 16, the TX FIFO depth in bytes (power of two).
REQ-004 SHALL have port s_axi_aclk, input, 1, the clock; all logic is on its rising edge.
REQ-005 SHALL have port s_axi_aresetn, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port addr_in, input, ADDR_WIDTH, the register address from the AXI4-lite slave.
REQ-007 SHALL have port we, input, 1, a single-cycle register write strobe.
REQ-008 SHALL have port w_data_in, input, 8, the write data byte.
REQ-009 SHALL have port tx_fifo_clr, input, 1, a synchronous FIFO flush (FCR bit 2).
REQ-010 SHALL have port dl, input, 16, the baud divisor; dl==0 means the transmitter is halted.
REQ-011 SHALL have port tf_overrun, output, 1, a sticky dropped-write flag for the AXI4-lite slave.
REQ-012 SHALL have port tf_count, output, $clog2(DEPTH)+1, the FIFO occupancy.
REQ-013 SHALL have port tf_empty, output, 1, asserted when tf_count==0.
REQ-014 SHALL have port tx_busy, output, 1, asserted when the serialiser is not IDLE.
REQ-015 SHALL have port stx_o, output, 1, the serial TX line (idle high).

Function
REQ-016 A push SHALL occur when we && addr_in==TR_ADDR, and either tf_count<DEPTH or a pop occurs in the same cycle.
REQ-017 A write to TR_ADDR with a full FIFO and no same-cycle pop SHALL drop the byte and set tf_overrun on the next edge.
REQ-018 tf_overrun SHALL clear on the next accepted push or on tx_fifo_clr; otherwise it SHALL hold.
REQ-019 A write to any other address SHALL be ignored.
REQ-020 The FIFO SHALL be circular, with read and write pointers wrapping modulo DEPTH.
REQ-021 On a simultaneous push and pop, tf_count SHALL be unchanged.
REQ-022 tx_fifo_clr SHALL zero both pointers and tf_count on the next edge, with priority over a same-cycle push.
REQ-023 tx_fifo_clr SHALL NOT abort a character already in the serialiser.
REQ-024 Baud prescaler: a counter SHALL produce a 1-cycle enable every dl clocks.
REQ-025 The prescaler SHALL reload when dl changes or dl==0; dl==0 SHALL produce no enables.
REQ-026 Serialiser states SHALL be IDLE, START, DATA, STOP.
REQ-027 IDLE: stx_o=1; when !tf_empty && dl!=0, the serialiser SHALL pop the head byte into the shift register that cycle and enter START on the next edge.
REQ-028 START: stx_o=0 for 16 enables, then DATA.
REQ-029 DATA: stx_o SHALL carry shift[0], LSB first; each bit SHALL last 16 enables; after bit 7, the state SHALL go to STOP.
REQ-030 STOP: stx_o=1 for 16 enables, then IDLE.
REQ-031 Back-to-back characters SHALL incur exactly 1 extra clock in IDLE between STOP and the next START.
REQ-032 Bit time SHALL be 16*dl clocks; one character SHALL be 160*dl clocks plus the 1 IDLE clock.
REQ-033 A dl change mid-character SHALL take effect from the next enable; the state and bit counter SHALL be kept.
REQ-034 tf_count, tf_empty and tf_overrun SHALL be registered outputs and SHALL reflect a push/pop one clock after the strobe edge.

Reset
REQ-035 On s_axi_aresetn low (asynchronous), the block SHALL force: pointers=0, tf_count=0, tf_empty=1, tf_overrun=0, tx_busy=0, stx_o=1, state=IDLE, prescaler=0, bit counter=0.
REQ-036 Reset asserted mid-character SHALL drive stx_o high immediately (no completion of the character).
REQ-037 Reset asserted mid-character SHALL discard the FIFO contents.
REQ-038 After reset release, the first push SHALL be accepted on the first clock edge.

Verification
REQ-039 dl=1, write 0xA5 to TR_ADDR -> stx_o low 16 clocks, then 1,0,1,0,0,1,0,1 (16 clocks each), high 16 clocks; tf_empty back to 1 one clock after the push.
REQ-040 dl=0, 16 writes 0x00..0x0F -> tf_count=16, tf_overrun=0; 17th write -> tf_overrun=1, tf_count=16; 18th write still dropped, tf_overrun stays 1.
REQ-041 Full FIFO with dl=0; set dl=2, then write 0x55 in the pop cycle -> push accepted, tf_count stays 16, tf_overrun=0; bytes appear on stx_o in order 0x00..0x0F, 0x55.
REQ-042 dl=0, 5 bytes queued, tx_fifo_clr with a same-cycle write -> tf_count=0, tf_empty=1, tf_overrun=0; dl=1 -> stx_o stays high.
REQ-043 dl=3, reset pulsed during DATA bit 3 -> stx_o=1 and tx_busy=0 immediately; tf_count=0; a new write after release transmits normally.
REQ-044 we with addr_in=5'h03, data 0xFF -> tf_count=0, stx_o stays high.
